fp_mult_seq: RTL and testbench
==============================

// Module: fp_mult_seq
// PURPOSE
//   Parametrised, sequential IEEE-754-style floating-point multiplier; successor to the single-precision
//   combinational unit. Multiplies true significands (hidden bit restored) with an iterative radix-2
//   shift-add datapath, normalises, optionally rounds and handles special operands.
//   Sits between operand staging and the result writeback, with valid/ready handshakes on both sides.
// PARAMETERS
//   EXP_W   8   exponent field width; BIAS = 2**(EXP_W-1)-1 (localparam, 127 at default)
//   FRAC_W  23  stored fraction width; significand width M = FRAC_W+1 (localparam)
// PORTS
//   clk        in   1              rising-edge clock
//   rst        in   1              asynchronous, active-high reset
//   in_valid   in   1              operands a/b valid
//   in_ready   out  1              block accepts operands (IDLE only)
//   a          in   1+EXP_W+FRAC_W {sign, exponent, fraction}
//   b          in   1+EXP_W+FRAC_W {sign, exponent, fraction}
//   out_valid  out  1              result valid; held until out_ready
//   out_ready  in   1              downstream accepts result
//   result     out  1+EXP_W+FRAC_W product
//   flags      out  3              {invalid, overflow, underflow}; qualified by out_valid
// BEHAVIOUR
//   Reset: state=IDLE, in_ready=1, out_valid=0, result=0, flags=0; reset mid-operation aborts, result discarded.
//   FSM: IDLE -(in_valid)-> MULT or DONE(special); MULT -(M iterations)-> NORM; NORM -> DONE; DONE -(out_ready)-> IDLE.
//   Accept: in_valid&in_ready in IDLE registers a/b; in_ready=0 in every other state, no same-cycle bypass.
//   Sign: sa^sb for every result, incl. zero/inf; canonical NaN sign=0.
//   Input classes: exp==0 -> zero (denormals flushed); exp==all-ones,frac==0 -> inf; frac!=0 -> NaN.
//   Specials (IDLE -> DONE, out_valid 1 cycle after accept):
//     NaN operand or 0*inf -> NaN {0,all-ones,1000..0}, invalid=1; inf*x -> inf; 0*x -> signed zero, flags=0.
//   MULT: M cycles; per cycle, if multiplier LSB=1 add multiplicand to 2M-bit accumulator, shift. Counter 0..M-1.
//   NORM: p = 2M-bit product, range [1,4). If p[2M-1]: frac=p[2M-2-:FRAC_W], exp+1; else frac=p[2M-3-:FRAC_W].
//     guard = next bit below frac; sticky = OR of all lower bits.
//   Exponent: signed EXP_W+2 bits: e = ea + eb - BIAS (+1 normalise, +1 rounding carry-out).
//     e >= 2**EXP_W-1 -> inf, overflow=1; e <= 0 -> signed zero, underflow=1 (no denormal outputs).
//   Normal latency: out_valid asserted M+2 cycles after the accept edge (26 at defaults).
//   DONE: result/flags stable while out_valid=1 and out_ready=0; out_valid drops the cycle after out_ready.
//   Simultaneous in_valid in DONE ignored (in_ready=0); operand changes after accept have no effect.
// CONFIGURATION
//   FP_MULT_RNE_EN defined: round-to-nearest-even in NORM; increment if guard&(sticky|frac LSB);
//     fraction carry-out -> frac=0, exp+1; overflow evaluated after rounding.
//   Not defined: truncation (round toward zero); guard/sticky computed but unused; latency identical.
// TESTING (defaults EXP_W=8, FRAC_W=23)
//   0x3FC00000 * 0x40000000 -> 0x40400000, flags=000, out_valid exactly 26 cycles after accept
//   0xC0400000 * 0x3F000000 -> 0xBFC00000; hold out_ready=0 10 cycles -> result/out_valid stable
//   0x7F800000 * 0x00000000 -> 0x7FC00000, flags=100, out_valid 1 cycle after accept
//   0x7F000000 * 0x7F000000 -> 0x7F800000 flags=010; 0x00800000 * 0x00800000 -> 0x00000000 flags=001
//   0x3FC00001 * 0x3FC00001 -> 0x40100001 (no macro) / 0x40100002 (FP_MULT_RNE_EN)
//   Assert rst in MULT cycle 10 -> out_valid=0, in_ready=1 next cycle; next op 0x3F800000*0x3F800000 -> 0x3F800000

Source files
------------

// File: rtl/fp_mult_seq.sv
// Sequential floating-point multiplier: radix-2 shift-add significand product, normalise, round/truncate.
// Optional round-to-nearest-even when FP_MULT_RNE_EN is defined; otherwise truncation (round toward zero).
module fp_mult_seq #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   a,
    input  logic [EXP_W+FRAC_W:0]   b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic [2:0]              flags,
    output logic [1:0]              o_dbg_state,
    output logic                    o_dbg_inexact
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and result/flags hold until taken.

    localparam int W     = 1 + EXP_W + FRAC_W;
    localparam int M     = FRAC_W + 1;
    localparam int EW2   = EXP_W + 2;
    localparam int CNT_W = $clog2(M);
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

    localparam logic signed [EW2-1:0] BIAS_S = EW2'(BIAS);
    localparam logic signed [EW2-1:0] EMAX_S = EW2'((1 << EXP_W) - 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(M - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [2*M-1:0]          r_acc;
    logic [M-1:0]            r_mcand;
    logic signed [EW2-1:0]   r_exp;
    logic                    r_sign;
    logic [W-1:0]            r_result;
    logic [2:0]              r_flags;
    logic                    r_inexact;

    // Operand classification
    logic                    w_a_sign, w_b_sign, w_sign;
    logic [EXP_W-1:0]        w_a_exp, w_b_exp;
    logic [FRAC_W-1:0]       w_a_frac, w_b_frac;
    logic                    w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic                    w_special;
    logic [W-1:0]            w_spec_result;
    logic [2:0]              w_spec_flags;
    logic signed [EW2-1:0]   w_exp_sum;

    assign w_a_sign = a[W-1];
    assign w_b_sign = b[W-1];
    assign w_a_exp  = a[FRAC_W +: EXP_W];
    assign w_b_exp  = b[FRAC_W +: EXP_W];
    assign w_a_frac = a[FRAC_W-1:0];
    assign w_b_frac = b[FRAC_W-1:0];
    assign w_sign   = w_a_sign ^ w_b_sign;

    assign w_a_zero = (w_a_exp == '0);
    assign w_b_zero = (w_b_exp == '0);
    assign w_a_inf  = (&w_a_exp) && (w_a_frac == '0);
    assign w_b_inf  = (&w_b_exp) && (w_b_frac == '0);
    assign w_a_nan  = (&w_a_exp) && (w_a_frac != '0);
    assign w_b_nan  = (&w_b_exp) && (w_b_frac != '0);

    assign w_special = w_a_zero | w_b_zero | w_a_inf | w_b_inf | w_a_nan | w_b_nan;
    assign w_exp_sum = EW2'(w_a_exp) + EW2'(w_b_exp) - BIAS_S;

    // Priority: NaN (incl. 0*inf) over inf over zero; exponent-0 inputs count as zero.
    always_comb begin
        w_spec_result = '0;
        w_spec_flags  = 3'b000;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_inf) || (w_a_inf && w_b_zero)) begin
            w_spec_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
            w_spec_flags  = 3'b100;
        end else if (w_a_inf || w_b_inf) begin
            w_spec_result = {w_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else begin
            w_spec_result = {w_sign, {(W-1){1'b0}}};
        end
    end

    // Shift-add step: conditionally add the multiplicand to the upper half, then shift right.
    logic [M:0]              w_sum;
    logic [2*M-1:0]          w_acc_next;

    assign w_sum      = {1'b0, r_acc[2*M-1:M]} + (r_acc[0] ? {1'b0, r_mcand} : {(M+1){1'b0}});
    assign w_acc_next = {w_sum, r_acc[M-1:1]};

    // Normalisation of the [1,4) product and rounding
    logic                    w_norm_hi;
    logic [FRAC_W-1:0]       w_frac_t;
    logic                    w_guard, w_sticky;
    logic                    w_round_inc;
    logic                    w_carry;
    logic [FRAC_W-1:0]       w_frac_f;
    logic signed [EW2-1:0]   w_exp_n, w_exp_f;
    logic                    w_ovf, w_unf;
    logic [W-1:0]            w_norm_result;
    logic [2:0]              w_norm_flags;

    assign w_norm_hi = r_acc[2*M-1];
    assign w_frac_t  = w_norm_hi ? r_acc[2*M-2 -: FRAC_W] : r_acc[2*M-3 -: FRAC_W];
    assign w_guard   = w_norm_hi ? r_acc[M-1] : r_acc[M-2];
    assign w_sticky  = w_norm_hi ? (|r_acc[M-2:0]) : (|r_acc[M-3:0]);
    assign w_exp_n   = r_exp + {{(EW2-1){1'b0}}, w_norm_hi};

`ifdef FP_MULT_RNE_EN
    assign w_round_inc = w_guard & (w_sticky | w_frac_t[0]);
`else
    assign w_round_inc = 1'b0;
`endif

    // A carry out of the fraction leaves it all-zero, which is exactly the renormalised value.
    assign {w_carry, w_frac_f} = {1'b0, w_frac_t} + {{FRAC_W{1'b0}}, w_round_inc};
    assign w_exp_f = w_exp_n + {{(EW2-1){1'b0}}, w_carry};

    assign w_ovf = (w_exp_f >= EMAX_S);
    assign w_unf = w_exp_f[EW2-1] || (w_exp_f == '0);

    always_comb begin
        w_norm_result = {r_sign, w_exp_f[EXP_W-1:0], w_frac_f};
        w_norm_flags  = 3'b000;
        if (w_ovf) begin
            w_norm_result = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            w_norm_flags  = 3'b010;
        end else if (w_unf) begin
            w_norm_result = {r_sign, {(W-1){1'b0}}};
            w_norm_flags  = 3'b001;
        end
    end

    // FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next_state = w_special ? S_DONE : S_MULT;
            S_MULT: if (r_cnt == CNT_LAST) w_next_state = S_NORM;
            S_NORM: w_next_state = S_DONE;
            S_DONE: if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_exp     <= '0;
            r_sign    <= 1'b0;
            r_result  <= '0;
            r_flags   <= 3'b000;
            r_inexact <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign <= w_sign;
                        if (w_special) begin
                            r_result  <= w_spec_result;
                            r_flags   <= w_spec_flags;
                            r_inexact <= 1'b0;
                        end else begin
                            r_acc   <= {{M{1'b0}}, 1'b1, w_b_frac};
                            r_mcand <= {1'b1, w_a_frac};
                            r_exp   <= w_exp_sum;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_MULT: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_NORM: begin
                    r_result  <= w_norm_result;
                    r_flags   <= w_norm_flags;
                    r_inexact <= w_guard | w_sticky;
                end
                default: ;
            endcase
        end
    end

    assign in_ready      = (r_state == S_IDLE);
    assign out_valid     = (r_state == S_DONE);
    assign result        = r_result;
    assign flags         = r_flags;
    assign o_dbg_state   = r_state;
    assign o_dbg_inexact = r_inexact;

endmodule

// File: tb/tb_fp_mult_seq.sv
// Directed bench for fp_mult_seq at default parameters: specials, normal products, hold, mid-op reset.
module tb_fp_mult_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;
  logic [1:0]  dbg_state;
  logic        dbg_inexact;

  int n_checks;
  int n_fail;
  logic [31:0] exp_q[$];

  fp_mult_seq #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a             (a),
    .b             (b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .flags         (flags),
    .o_dbg_state   (dbg_state),
    .o_dbg_inexact (dbg_inexact)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one operation, wait for the result, compare, optionally hold, then take it.
  task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                       input logic [31:0] exp_r, input logic [2:0] exp_f,
                       input int exp_lat, input int hold);
    int lat;
    logic [31:0] got_exp;
    logic [31:0] held;
    exp_q.push_back(exp_r);
    @(negedge clk);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 1;
    @(negedge clk);
    if (exp_lat > 1) check({tag, "_busy"}, 32'(in_ready), 32'd0);
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    got_exp = exp_q.pop_front();
    check({tag, "_result"}, result, got_exp);
    check({tag, "_flags"}, 32'(flags), 32'(exp_f));
    held = result;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = 32'h40000000;
      b = 32'h40000000;
      @(negedge clk);
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_result"}, result, held);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // normal products
    do_op("mul_1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 26, 0);
    do_op("mul_neg3xhalf", 32'hC0400000, 32'h3F000000, 32'hBFC00000, 3'b000, 26, 10);
`ifdef FP_MULT_RNE_EN
    do_op("mul_round", 32'h3FC00001, 32'h3FC00001, 32'h40100002, 3'b000, 26, 0);
`else
    do_op("mul_round", 32'h3FC00001, 32'h3FC00001, 32'h40100001, 3'b000, 26, 0);
`endif
    do_op("mul_ovf", 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010, 26, 0);
    do_op("mul_unf", 32'h00800000, 32'h00800000, 32'h00000000, 3'b001, 26, 0);

    // special operands
    do_op("sp_infx0", 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100, 1, 0);
    do_op("sp_nan", 32'hFFC00001, 32'h3F800000, 32'h7FC00000, 3'b100, 1, 0);
    do_op("sp_infxneg", 32'h7F800000, 32'hC0000000, 32'hFF800000, 3'b000, 1, 0);
    do_op("sp_negzero", 32'h80000000, 32'h3F800000, 32'h80000000, 3'b000, 1, 0);
    do_op("sp_denorm", 32'h00400000, 32'hC0000000, 32'h80000000, 3'b000, 1, 0);

    // reset during MULT aborts the operation
    @(negedge clk);
    a = 32'h3FC00000;
    b = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("abort_in_mult", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    check("abort_result", result, 32'h0);
    do_op("after_abort", 32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000, 26, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
